cordic_job_arbiter: RTL and testbench

- Shares one iterative CORDIC rotation core among NREQ requesters, e.g. FFT butterfly stages requesting twiddle rotations.
- Arbitrates round-robin and drives the core's xstart/ystart/zangle inputs, holding them stable for the core's fixed iteration latency.
- Captures xout/yout and returns them on a single response channel tagged with the requester index.
- Only one job is in flight at a time, because the core is not pipelined.

---
 rtl/cordic_pkg.sv | 32 +++
 rtl/cordic_rr_arbiter.sv | 30 +++
 rtl/cordic_job_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cordic_job_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC job arbiter slice.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int XY_W = 16;
    localparam int Z_W  = 32;

    localparam logic [Z_W-1:0] ANGLE_90  = 32'h4000_0000;
    localparam logic [Z_W-1:0] ANGLE_180 = 32'h8000_0000;

    // Two's complement negation where the most negative value saturates to the most positive.
    function automatic logic [XY_W-1:0] negSat(input logic [XY_W-1:0] v);
        logic [XY_W-1:0] mostNeg;
        mostNeg = {1'b1, {(XY_W-1){1'b0}}};
        if (v == mostNeg) begin
            return ~mostNeg;
        end
        return (~v) + XY_W'(1);
    endfunction

    // True for angles in the second or third quadrant, which lie outside the core's convergence range.
    function automatic logic needsPreRotate(input logic [Z_W-1:0] z);
        return (z[Z_W-1:Z_W-2] == ANGLE_90[Z_W-1:Z_W-2]) ||
               (z[Z_W-1:Z_W-2] == ANGLE_180[Z_W-1:Z_W-2]);
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module cordic_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    // Scan offsets from the far end back toward the pointer so the closest valid requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            int idx;
            idx = (int'(rr_ptr) + off) % NREQ;
            if (req_valid[IDW'(idx)]) begin
                grant            = '0;
                grant[IDW'(idx)] = 1'b1;
                grant_idx        = IDW'(idx);
                grant_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_job_arbiter.sv
// Shares one non-pipelined CORDIC core among NREQ requesters with round-robin arbitration.
// Optional macro CORDIC_ARB_QUADRANT_EN folds 90..270 degree jobs by 180 degrees before issue.
module cordic_job_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 16,
    parameter int IDW     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [XY_W*NREQ-1:0] req_x,
    input  logic [XY_W*NREQ-1:0] req_y,
    input  logic [Z_W*NREQ-1:0]  req_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XY_W-1:0]      rsp_x,
    output logic [XY_W-1:0]      rsp_y,
    output logic [XY_W-1:0]      cor_xstart,
    output logic [XY_W-1:0]      cor_ystart,
    output logic [Z_W-1:0]       cor_zangle,
    input  logic [XY_W-1:0]      cor_xout,
    input  logic [XY_W-1:0]      cor_yout
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t            state;
    state_t            stateNext;
    logic [IDW-1:0]    rrPtr;
    logic [IDW-1:0]    jobId;
    logic [CNT_W-1:0]  counter;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grantIdx;
    logic              grantAny;
    logic              handshake;
    logic              capture;
    logic              accept;
    logic [XY_W-1:0]   selX;
    logic [XY_W-1:0]   selY;
    logic [Z_W-1:0]    selZ;
    logic [XY_W-1:0]   loadX;
    logic [XY_W-1:0]   loadY;
    logic [Z_W-1:0]    loadZ;
    logic [IDW-1:0]    ptrAfterGrant;

    cordic_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rrPtr),
        .grant     (grant),
        .grant_idx (grantIdx),
        .grant_any (grantAny)
    );

    // Pull the granted requester's operands out of the packed input buses.
    always_comb begin
        selX = '0;
        selY = '0;
        selZ = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                selX = req_x[i*XY_W +: XY_W];
                selY = req_y[i*XY_W +: XY_W];
                selZ = req_z[i*Z_W +: Z_W];
            end
        end
    end

`ifdef CORDIC_ARB_QUADRANT_EN
    // Fold far-quadrant angles by 180 degrees and negate the vector so the core stays convergent.
    always_comb begin
        loadX = selX;
        loadY = selY;
        loadZ = selZ;
        if (needsPreRotate(selZ)) begin
            loadX = negSat(selX);
            loadY = negSat(selY);
            loadZ = selZ ^ ANGLE_180;
        end
    end
`else
    // Operands go to the core bit-exact; callers keep angles inside +/-90 degrees.
    always_comb begin
        loadX = selX;
        loadY = selY;
        loadZ = selZ;
    end
`endif

    // Next requester in line after the one just granted, wrapping at NREQ.
    always_comb begin
        ptrAfterGrant = grantIdx + IDW'(1);
        if (grantIdx == IDW'(NREQ - 1)) begin
            ptrAfterGrant = '0;
        end
    end

    // Next-state and handshake decode; grants are only offered while idle.
    always_comb begin
        stateNext = state;
        req_ready = '0;
        handshake = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (|(req_valid & grant)) begin
                    handshake = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (counter == '0) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    accept    = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Job datapath: latch operands on grant, count down the core latency, hold the result until taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            rrPtr      <= '0;
            jobId      <= '0;
            counter    <= '0;
            cor_xstart <= '0;
            cor_ystart <= '0;
            cor_zangle <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_x      <= '0;
            rsp_y      <= '0;
        end else begin
            if (handshake) begin
                cor_xstart <= loadX;
                cor_ystart <= loadY;
                cor_zangle <= loadZ;
                jobId      <= grantIdx;
                counter    <= CNT_W'(LATENCY - 1);
                rrPtr      <= ptrAfterGrant;
            end
            if (state == RUN && counter != '0) begin
                counter <= counter - CNT_W'(1);
            end
            if (capture) begin
                rsp_x     <= cor_xout;
                rsp_y     <= cor_yout;
                rsp_id    <= jobId;
                rsp_valid <= 1'b1;
            end
            if (accept) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Self-checking bench for cordic_job_arbiter with a delay-line core stub and a behavioural model.
module tb_cordic_job_arbiter;

    localparam int NREQ    = 4;
    localparam int LATENCY = 16;
    localparam int IDW     = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [63:0]   req_x;
    logic [63:0]   req_y;
    logic [127:0]  req_z;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_x;
    logic [15:0]   rsp_y;
    logic [15:0]   cor_xstart;
    logic [15:0]   cor_ystart;
    logic [31:0]   cor_zangle;
    logic [15:0]   cor_xout;
    logic [15:0]   cor_yout;

    logic [15:0]   bx [NREQ];
    logic [15:0]   by [NREQ];
    logic [31:0]   bz [NREQ];
    logic [15:0]   px [LATENCY-1];
    logic [15:0]   py [LATENCY-1];

    int passCount  = 0;
    int checkCount = 0;
    int mPtr       = 0;

    cordic_job_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .cor_xstart(cor_xstart), .cor_ystart(cor_ystart), .cor_zangle(cor_zangle),
        .cor_xout(cor_xout), .cor_yout(cor_yout)
    );

    always #5 clock = ~clock;

    // Pack the per-requester operand arrays onto the DUT buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*16 +: 16] = bx[i];
            req_y[i*16 +: 16] = by[i];
            req_z[i*32 +: 32] = bz[i];
        end
    end

    // Core stub: outputs reflect the inputs seen LATENCY edges before the arbiter samples them.
    always @(posedge clock) begin
        px[0] <= cor_xstart;
        py[0] <= cor_ystart;
        for (int i = 1; i < LATENCY - 1; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end
    assign cor_xout = px[LATENCY-2] + 16'd1;
    assign cor_yout = py[LATENCY-2] + 16'd2;

    // Round-robin reference: first valid requester scanning upward from the pointer.
    function automatic int modelPick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic inFarQuadrant(input logic [31:0] z);
        return (z >= 32'h4000_0000) && (z < 32'hC000_0000);
    endfunction

    // Expected value presented to the core for x or y.
    function automatic logic [15:0] modelCorXY(input logic [15:0] v, input logic [31:0] z);
        int s;
        s = $signed(v);
`ifdef CORDIC_ARB_QUADRANT_EN
        if (inFarQuadrant(z)) begin
            s = -s;
            if (s > 32767) s = 32767;
        end
`else
        if (inFarQuadrant(z)) s = s;
`endif
        return 16'(s);
    endfunction

    // Expected angle presented to the core.
    function automatic logic [31:0] modelCorZ(input logic [31:0] z);
`ifdef CORDIC_ARB_QUADRANT_EN
        if (inFarQuadrant(z)) return z - 32'h8000_0000;
`endif
        return z;
    endfunction

    task automatic nextCycle();
        @(negedge clock);
        #1;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) nextCycle();
        reset = 1'b0;
        mPtr  = 0;
    endtask

    task automatic randomizeData();
        for (int i = 0; i < NREQ; i++) begin
            bx[i] = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            by[i] = 16'($urandom);
            bz[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        randomizeData();
        doReset();
        #1;
        checkCount++;
        if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid);
        else passCount++;
        checkCount++;
        if ({rsp_id, rsp_x, rsp_y} !== 34'd0) $display("[TB] FAIL reset_rsp_data got %h expected 0", {rsp_id, rsp_x, rsp_y});
        else passCount++;
        checkCount++;
        if ({cor_xstart, cor_ystart, cor_zangle} !== 64'd0) $display("[TB] FAIL reset_cor got %h expected 0", {cor_xstart, cor_ystart, cor_zangle});
        else passCount++;
        checkCount++;
        if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready got %b expected 0000", req_ready);
        else passCount++;
    endtask

    task automatic test_single();
        int lat;
        randomizeData();
        doReset();
        rsp_ready = 1'b1;
        bx[2] = 16'd32000;
        by[2] = 16'd0;
        bz[2] = 32'h2000_0000;
        req_valid = 4'b0100;
        #1;
        checkCount++;
        if (req_ready !== 4'b0100) $display("[TB] FAIL single_grant got %b expected 0100", req_ready);
        else passCount++;
        nextCycle();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            nextCycle();
            lat++;
        end
        checkCount++;
        if (lat !== LATENCY) $display("[TB] FAIL single_latency got %0d expected %0d", lat, LATENCY);
        else passCount++;
        checkCount++;
        if ({rsp_id, rsp_x, rsp_y} !== {2'd2, 16'd32001, 16'd2})
            $display("[TB] FAIL single_result got id=%0d x=%0d y=%0d expected id=2 x=32001 y=2", rsp_id, rsp_x, rsp_y);
        else passCount++;
        nextCycle();
        checkCount++;
        if (rsp_valid !== 1'b0) $display("[TB] FAIL single_accept got %b expected 0", rsp_valid);
        else passCount++;
    endtask

    task automatic test_fairness();
        int grants;
        int lastGrant;
        int expG;
        int qId[$];
        logic [15:0] qX[$];
        logic [15:0] qY[$];
        randomizeData();
        doReset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        grants = 0;
        lastGrant = 0;
        for (int cyc = 0; cyc < 120 && grants < 5; cyc++) begin
            #1;
            if (rsp_valid) begin
                checkCount++;
                if (qId.size() == 0) $display("[TB] FAIL fair_unexpected_rsp got id=%0d expected none", rsp_id);
                else if ({rsp_id, rsp_x, rsp_y} !== {2'(qId[0]), qX[0], qY[0]})
                    $display("[TB] FAIL fair_rsp got id=%0d x=%h y=%h expected id=%0d x=%h y=%h", rsp_id, rsp_x, rsp_y, qId[0], qX[0], qY[0]);
                else passCount++;
                if (qId.size() != 0) begin
                    void'(qId.pop_front());
                    void'(qX.pop_front());
                    void'(qY.pop_front());
                end
            end
            if (req_ready != 4'b0000) begin
                expG = modelPick(4'hF, mPtr);
                checkCount++;
                if (req_ready !== 4'(1 << expG)) $display("[TB] FAIL fair_grant%0d got %b expected requester %0d", grants, req_ready, expG);
                else passCount++;
                if (grants > 0) begin
                    checkCount++;
                    if (cyc - lastGrant !== LATENCY + 2) $display("[TB] FAIL fair_gap got %0d expected %0d", cyc - lastGrant, LATENCY + 2);
                    else passCount++;
                end
                qId.push_back(expG);
                qX.push_back(modelCorXY(bx[expG], bz[expG]) + 16'd1);
                qY.push_back(modelCorXY(by[expG], bz[expG]) + 16'd2);
                mPtr = (expG + 1) % NREQ;
                lastGrant = cyc;
                grants++;
            end
            nextCycle();
        end
        req_valid = '0;
        checkCount++;
        if (grants !== 5) $display("[TB] FAIL fair_grant_count got %0d expected 5", grants);
        else passCount++;
    endtask

    task automatic test_backpressure();
        int lat;
        int expG;
        logic [33:0] held;
        randomizeData();
        doReset();
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        expG = modelPick(req_valid, mPtr);
        checkCount++;
        if (req_ready !== 4'(1 << expG)) $display("[TB] FAIL bp_grant got %b expected requester %0d", req_ready, expG);
        else passCount++;
        mPtr = (expG + 1) % NREQ;
        held = {2'(expG), modelCorXY(bx[expG], bz[expG]) + 16'd1, modelCorXY(by[expG], bz[expG]) + 16'd2};
        nextCycle();
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            nextCycle();
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkCount++;
            if ({rsp_valid, req_ready, rsp_id, rsp_x, rsp_y} !== {1'b1, 4'b0000, held})
                $display("[TB] FAIL bp_hold%0d got v=%b rdy=%b data=%h expected v=1 rdy=0000 data=%h", i, rsp_valid, req_ready, {rsp_id, rsp_x, rsp_y}, held);
            else passCount++;
        end
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        expG = modelPick(req_valid, mPtr);
        checkCount++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'(1 << expG)})
            $display("[TB] FAIL bp_regrant got v=%b rdy=%b expected v=0 requester %0d", rsp_valid, req_ready, expG);
        else passCount++;
        nextCycle();
        req_valid = '0;
        checkCount++;
        if (cor_xstart !== modelCorXY(bx[expG], bz[expG])) $display("[TB] FAIL bp_next_job got %h expected %h", cor_xstart, modelCorXY(bx[expG], bz[expG]));
        else passCount++;
    endtask

    task automatic test_reset_mid_run();
        logic sawRsp;
        randomizeData();
        doReset();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        nextCycle();
        req_valid = '0;
        repeat (4) nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        mPtr = 0;
        checkCount++;
        if ({rsp_valid, req_ready, cor_xstart} !== 21'd0) $display("[TB] FAIL abort_state got v=%b rdy=%b cx=%h expected all 0", rsp_valid, req_ready, cor_xstart);
        else passCount++;
        sawRsp = 1'b0;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        checkCount++;
        if (sawRsp !== 1'b0) $display("[TB] FAIL abort_no_rsp got a response expected none");
        else passCount++;
        req_valid = 4'hF;
        #1;
        checkCount++;
        if (req_ready !== 4'(1 << modelPick(4'hF, mPtr))) $display("[TB] FAIL abort_ptr got %b expected 0001", req_ready);
        else passCount++;
        req_valid = '0;
    endtask

    task automatic test_quadrant();
        int lat;
        logic [63:0] expCor;
        randomizeData();
        doReset();
        rsp_ready = 1'b1;
        bx[0] = 16'd1000;
        by[0] = -16'sd200;
        bz[0] = 32'h7555_5555;
        req_valid = 4'b0001;
        nextCycle();
        req_valid = '0;
`ifdef CORDIC_ARB_QUADRANT_EN
        expCor = {-16'sd1000, 16'sd200, 32'hF555_5555};
`else
        expCor = {16'sd1000, -16'sd200, 32'h7555_5555};
`endif
        checkCount++;
        if ({cor_xstart, cor_ystart, cor_zangle} !== expCor)
            $display("[TB] FAIL quad_cor got %h expected %h", {cor_xstart, cor_ystart, cor_zangle}, expCor);
        else passCount++;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            nextCycle();
            lat++;
        end
        checkCount++;
        if ({rsp_x, rsp_y} !== {expCor[63:48] + 16'd1, expCor[47:32] + 16'd2})
            $display("[TB] FAIL quad_rsp got %h expected %h", {rsp_x, rsp_y}, {expCor[63:48] + 16'd1, expCor[47:32] + 16'd2});
        else passCount++;
        nextCycle();
    endtask

    task automatic test_pulse();
        int lat;
        logic stray;
        randomizeData();
        doReset();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        nextCycle();
        req_valid = '0;
        repeat (3) nextCycle();
        req_valid = 4'b0010;
        #1;
        checkCount++;
        if (req_ready !== 4'b0000) $display("[TB] FAIL pulse_no_grant got %b expected 0000", req_ready);
        else passCount++;
        nextCycle();
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            nextCycle();
            lat++;
        end
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) stray = 1'b1;
        end
        checkCount++;
        if (stray !== 1'b0) $display("[TB] FAIL pulse_stray got activity expected idle");
        else passCount++;
    endtask

    task automatic test_random();
        int lat;
        int expG;
        logic [3:0] mask;
        doReset();
        rsp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            randomizeData();
            mask = 4'($urandom_range(1, 15));
            req_valid = mask;
            #1;
            expG = modelPick(mask, mPtr);
            checkCount++;
            if (req_ready !== 4'(1 << expG)) $display("[TB] FAIL rand%0d_grant got %b expected requester %0d (mask %b)", j, req_ready, expG, mask);
            else passCount++;
            mPtr = (expG + 1) % NREQ;
            nextCycle();
            req_valid = '0;
            checkCount++;
            if (cor_zangle !== modelCorZ(bz[expG])) $display("[TB] FAIL rand%0d_z got %h expected %h", j, cor_zangle, modelCorZ(bz[expG]));
            else passCount++;
            lat = 0;
            while (!rsp_valid && lat < 40) begin
                nextCycle();
                lat++;
            end
            checkCount++;
            if ({lat, rsp_id, rsp_x, rsp_y} !== {LATENCY, 2'(expG), modelCorXY(bx[expG], bz[expG]) + 16'd1, modelCorXY(by[expG], bz[expG]) + 16'd2})
                $display("[TB] FAIL rand%0d_rsp got lat=%0d id=%0d x=%h y=%h expected lat=%0d id=%0d x=%h y=%h", j, lat, rsp_id, rsp_x, rsp_y,
                         LATENCY, expG, modelCorXY(bx[expG], bz[expG]) + 16'd1, modelCorXY(by[expG], bz[expG]) + 16'd2);
            else passCount++;
            nextCycle();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid_run();
        test_quadrant();
        test_pulse();
        test_random();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
